// File: rtl/bj_pkg.sv
// Shared constants, state encoding and rank helper for the blackjack card path.
// Imported by card_shoe and its LFSR sub-module.
package bj_pkg;

    localparam int         DECK_SIZE  = 52;
    localparam int         RANKS      = 13;
    localparam logic [3:0] ACE        = 4'd1;
    localparam logic [3:0] FACE_VALUE = 4'd10;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        SHUFFLE = 2'd1,
        READY   = 2'd2
    } state_e;

    // Blackjack value of a rank: J/Q/K count as ten, ace counts as one.
    function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
        rank_to_value = (rank > FACE_VALUE) ? FACE_VALUE : rank;
    endfunction

endpackage

// File: rtl/bj_lfsr16.sv
// Free-running 16-bit Galois LFSR, loaded with SEED on reset.
// Ports: clk, reset (async, active-high), state_o (current LFSR state).
module bj_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: builds the deck, Fisher-Yates shuffles it from an LFSR, deals on request.
// Ports: clk, reset, test_mode, shuffle_req, deal_req -> ready, deal_valid, card_rank,
//        card_value, is_ace, cards_left, shoe_empty.
module card_shoe
    import bj_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       test_mode,
    input  logic       shuffle_req,
    input  logic       deal_req,
    output logic       ready,
    output logic       deal_valid,
    output logic [3:0] card_rank,
    output logic [3:0] card_value,
    output logic       is_ace,
    output logic [5:0] cards_left,
    output logic       shoe_empty
);

    localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
    localparam logic [5:0] FULL = 6'(DECK_SIZE);

    state_e     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [3:0] irank_q, irank_d;
    logic [5:0] i_q, i_d;
    logic [5:0] ptr_q, ptr_d;
    logic [5:0] left_q, left_d;
    logic       tm_q, tm_d;
    logic       valid_q, valid_d;
    logic [3:0] crank_q, crank_d;
    logic [3:0] cval_q, cval_d;
    logic       ace_q, ace_d;

    logic [3:0]  deck [DECK_SIZE];
    logic [15:0] lfsr;
    logic [5:0]  cand;
    logic        take;
    logic        accept;
    logic [3:0]  top_card;
    logic        lfsr_unused;

    bj_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .state_o (lfsr)
    );

    assign cand        = lfsr[5:0];
    assign lfsr_unused = ^lfsr[15:6];
    assign top_card    = deck[ptr_q];

    // A candidate above i is rejected; the LFSR moves on and is retried next cycle.
    assign take   = (state_q == SHUFFLE) && !tm_q && (cand <= i_q);
    // Shuffle wins over a simultaneous deal.
    assign accept = (state_q == READY) && deal_req && !shuffle_req
                    && (left_q != 6'd0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: begin
                if (idx_q == LAST) state_d = SHUFFLE;
            end
            SHUFFLE: begin
                if (tm_q || (take && (i_q == 6'd1))) state_d = READY;
            end
            READY: begin
                if (shuffle_req) state_d = INIT;
            end
            default: state_d = INIT;
        endcase
    end

    // Output logic
    always_comb begin
        ready      = (state_q == READY) && (left_q != 6'd0);
        shoe_empty = (state_q == READY) && (left_q == 6'd0);
    end

    // Datapath next-state
    always_comb begin
        idx_d   = idx_q;
        irank_d = irank_q;
        i_d     = i_q;
        ptr_d   = ptr_q;
        left_d  = left_q;
        tm_d    = tm_q;
        valid_d = 1'b0;
        crank_d = 4'd0;
        cval_d  = 4'd0;
        ace_d   = 1'b0;
        unique case (state_q)
            INIT: begin
                idx_d   = idx_q + 6'd1;
                irank_d = (irank_q == 4'(RANKS)) ? 4'd1 : irank_q + 4'd1;
                if (idx_q == LAST) begin
                    idx_d  = 6'd0;
                    i_d    = LAST;
                    ptr_d  = 6'd0;
                    left_d = FULL;
                    tm_d   = test_mode;
                end
            end
            SHUFFLE: begin
                if (take) i_d = i_q - 6'd1;
            end
            READY: begin
                if (shuffle_req) begin
                    idx_d   = 6'd0;
                    irank_d = 4'd1;
                    left_d  = 6'd0;
                end else if (accept) begin
                    ptr_d   = ptr_q + 6'd1;
                    left_d  = left_q - 6'd1;
                    valid_d = 1'b1;
                    crank_d = top_card;
                    cval_d  = rank_to_value(top_card);
                    ace_d   = (top_card == ACE);
                end
            end
            default: begin
                idx_d   = 6'd0;
                irank_d = 4'd1;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= 6'd0;
            irank_q <= 4'd1;
            i_q     <= 6'd0;
            ptr_q   <= 6'd0;
            left_q  <= 6'd0;
            tm_q    <= 1'b0;
            valid_q <= 1'b0;
            crank_q <= 4'd0;
            cval_q  <= 4'd0;
            ace_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            irank_q <= irank_d;
            i_q     <= i_d;
            ptr_q   <= ptr_d;
            left_q  <= left_d;
            tm_q    <= tm_d;
            valid_q <= valid_d;
            crank_q <= crank_d;
            cval_q  <= cval_d;
            ace_q   <= ace_d;
        end
    end

    // Deck storage: filled during INIT, permuted in place during SHUFFLE.
    // When cand == i both writes carry the same value, so the swap is a no-op.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            deck[idx_q] <= irank_q;
        end else if (take) begin
            deck[i_q]  <= deck[cand];
            deck[cand] <= deck[i_q];
        end
    end

    assign deal_valid = valid_q;
    assign card_rank  = crank_q;
    assign card_value = cval_q;
    assign is_ace     = ace_q;
    assign cards_left = left_q;

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: fixed order, empty shoe, shuffled deck,
// busy requests, shuffle/deal collision and asynchronous reset.
module tb_card_shoe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       test_mode = 1'b0;
    logic       shuffle_req = 1'b0;
    logic       deal_req = 1'b0;
    logic       ready;
    logic       deal_valid;
    logic [3:0] card_rank;
    logic [3:0] card_value;
    logic       is_ace;
    logic [5:0] cards_left;
    logic       shoe_empty;

    int errors = 0;
    int checks = 0;

    logic [3:0] model_deck [52];
    logic [3:0] run_a [52];
    logic [3:0] run_b [52];

    card_shoe #(
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .test_mode   (test_mode),
        .shuffle_req (shuffle_req),
        .deal_req    (deal_req),
        .ready       (ready),
        .deal_valid  (deal_valid),
        .card_rank   (card_rank),
        .card_value  (card_value),
        .is_ace      (is_ace),
        .cards_left  (cards_left),
        .shoe_empty  (shoe_empty)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        lstep = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic do_reset(input logic tm);
        test_mode   = tm;
        deal_req    = 1'b0;
        shuffle_req = 1'b0;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < budget);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, n);
        end
    endtask

    task automatic build_model();
        logic [15:0] l;
        logic [5:0]  c;
        logic [3:0]  t;
        int          i;
        int          guard;
        for (int k = 0; k < 52; k++) model_deck[k] = 4'(k % 13 + 1);
        l = 16'hACE1;
        repeat (52) l = lstep(l);
        i = 51;
        guard = 0;
        while (i >= 1 && guard < 60000) begin
            c = l[5:0];
            if (int'(c) <= i) begin
                t = model_deck[i];
                model_deck[i] = model_deck[c];
                model_deck[c] = t;
                i--;
            end
            l = lstep(l);
            guard++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, deal_valid, shoe_empty, is_ace} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: rdy/dv/empty/ace=%b required 0000",
                     {ready, deal_valid, shoe_empty, is_ace});
        end
        checks++;
        if (cards_left !== 6'd0) begin
            errors++;
            $display("FAIL reset_left: cards_left=%0d required 0", cards_left);
        end
        checks++;
        if ({card_rank, card_value} !== 8'h00) begin
            errors++;
            $display("FAIL reset_card: rank=%0d value=%0d required 0", card_rank, card_value);
        end
        do_reset(1'b1);
        wait_ready(200, n);
        checks++;
        if (n != 53) begin
            errors++;
            $display("FAIL ready_latency: %0d cycles required 53", n);
        end
        checks++;
        if (cards_left !== 6'd52) begin
            errors++;
            $display("FAIL ready_left: cards_left=%0d required 52", cards_left);
        end
    endtask

    task automatic test_fixed_order();
        int n;
        logic [3:0] er [14] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,1};
        logic [3:0] ev [14] = '{1,2,3,4,5,6,7,8,9,10,10,10,10,1};
        do_reset(1'b1);
        wait_ready(200, n);
        for (int k = 0; k < 14; k++) begin
            deal_req = 1'b1;
            @(negedge clk);
            checks++;
            if (deal_valid !== 1'b1 || card_rank !== er[k]) begin
                errors++;
                $display("FAIL fixed_rank[%0d]: dv=%b rank=%0d required 1/%0d",
                         k, deal_valid, card_rank, er[k]);
            end
            checks++;
            if (card_value !== ev[k]) begin
                errors++;
                $display("FAIL fixed_value[%0d]: %0d required %0d", k, card_value, ev[k]);
            end
            checks++;
            if (is_ace !== (er[k] == 4'd1)) begin
                errors++;
                $display("FAIL fixed_ace[%0d]: %b required %b", k, is_ace, er[k] == 4'd1);
            end
        end
        deal_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({deal_valid, card_rank, card_value, is_ace} !== 10'd0) begin
            errors++;
            $display("FAIL fixed_idle: dv=%b rank=%0d value=%0d ace=%b required all 0",
                     deal_valid, card_rank, card_value, is_ace);
        end
        checks++;
        if (cards_left !== 6'd38) begin
            errors++;
            $display("FAIL fixed_left: %0d required 38", cards_left);
        end
    endtask

    task automatic test_empty();
        int n;
        do_reset(1'b1);
        wait_ready(200, n);
        for (int k = 0; k < 52; k++) begin
            deal_req = 1'b1;
            @(negedge clk);
            deal_req = 1'b0;
            checks++;
            if (deal_valid !== 1'b1 || cards_left !== 6'(51 - k)
                || card_rank !== 4'(k % 13 + 1)) begin
                errors++;
                $display("FAIL empty_deal[%0d]: dv=%b left=%0d rank=%0d required 1/%0d/%0d",
                         k, deal_valid, cards_left, card_rank, 51 - k, k % 13 + 1);
            end
            @(negedge clk);
            checks++;
            if (deal_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_strobe[%0d]: dv=%b required 0", k, deal_valid);
            end
        end
        checks++;
        if (shoe_empty !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_flags: empty=%b ready=%b required 1/0", shoe_empty, ready);
        end
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        checks++;
        if (deal_valid !== 1'b0 || cards_left !== 6'd0) begin
            errors++;
            $display("FAIL empty_53rd: dv=%b left=%0d required 0/0", deal_valid, cards_left);
        end
        shuffle_req = 1'b1;
        @(negedge clk);
        shuffle_req = 1'b0;
        checks++;
        if (shoe_empty !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_reshuffle: empty=%b ready=%b required 0/0", shoe_empty, ready);
        end
        wait_ready(200, n);
        checks++;
        if (cards_left !== 6'd52) begin
            errors++;
            $display("FAIL empty_refill: left=%0d required 52", cards_left);
        end
    endtask

    task automatic shuffled_run(output logic [3:0] seq [52]);
        int n;
        do_reset(1'b0);
        wait_ready(20000, n);
        for (int k = 0; k < 52; k++) begin
            deal_req = 1'b1;
            @(negedge clk);
            seq[k] = deal_valid ? card_rank : 4'd0;
        end
        deal_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_shuffled();
        int cnt [14];
        bit diff_fixed;
        bit diff_runs;
        build_model();
        shuffled_run(run_a);
        for (int k = 0; k < 52; k++) begin
            checks++;
            if (run_a[k] !== model_deck[k]) begin
                errors++;
                $display("FAIL shuf_card[%0d]: rank=%0d required %0d", k, run_a[k], model_deck[k]);
            end
        end
        for (int r = 0; r < 14; r++) cnt[r] = 0;
        diff_fixed = 1'b0;
        for (int k = 0; k < 52; k++) begin
            if (run_a[k] <= 4'd13) cnt[run_a[k]]++;
            if (run_a[k] != 4'(k % 13 + 1)) diff_fixed = 1'b1;
        end
        for (int r = 1; r <= 13; r++) begin
            checks++;
            if (cnt[r] != 4) begin
                errors++;
                $display("FAIL shuf_count[%0d]: %0d required 4", r, cnt[r]);
            end
        end
        checks++;
        if (!diff_fixed) begin
            errors++;
            $display("FAIL shuf_order: shuffled order equals fixed order");
        end
        shuffled_run(run_b);
        diff_runs = 1'b0;
        for (int k = 0; k < 52; k++) if (run_b[k] !== run_a[k]) diff_runs = 1'b1;
        checks++;
        if (diff_runs) begin
            errors++;
            $display("FAIL shuf_repeat: second run differs, first cards %0d/%0d",
                     run_b[0], run_a[0]);
        end
    endtask

    task automatic test_busy();
        int n;
        bit seen;
        do_reset(1'b1);
        deal_req = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!ready && n < 200) begin
            shuffle_req = (n == 20);
            @(negedge clk);
            n++;
            if (deal_valid) seen = 1'b1;
        end
        deal_req = 1'b0;
        shuffle_req = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL busy_strobe: deal_valid=1 required 0 while busy");
        end
        checks++;
        if (n != 53) begin
            errors++;
            $display("FAIL busy_latency: ready after %0d cycles required 53", n);
        end
        checks++;
        if (cards_left !== 6'd52) begin
            errors++;
            $display("FAIL busy_left: %0d required 52", cards_left);
        end
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        checks++;
        if (deal_valid !== 1'b1 || card_rank !== 4'd1) begin
            errors++;
            $display("FAIL busy_first: dv=%b rank=%0d required 1/1", deal_valid, card_rank);
        end
    endtask

    task automatic test_collision();
        int n;
        do_reset(1'b1);
        wait_ready(200, n);
        deal_req = 1'b1;
        repeat (42) @(negedge clk);
        deal_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cards_left !== 6'd10) begin
            errors++;
            $display("FAIL coll_left: %0d required 10", cards_left);
        end
        deal_req = 1'b1;
        shuffle_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        shuffle_req = 1'b0;
        checks++;
        if (deal_valid !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_drop: dv=%b ready=%b required 0/0", deal_valid, ready);
        end
        wait_ready(200, n);
        checks++;
        if (cards_left !== 6'd52 || n != 53) begin
            errors++;
            $display("FAIL coll_refill: left=%0d cycles=%0d required 52/53", cards_left, n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset(1'b0);
        repeat (60) @(negedge clk);
        checks++;
        if (cards_left !== 6'd52 || ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_shuffle: left=%0d ready=%b required 52/0", cards_left, ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (cards_left !== 6'd0 || {ready, shoe_empty, deal_valid} !== 3'b000) begin
            errors++;
            $display("FAIL mid_async: left=%0d rdy/empty/dv=%b required 0/000",
                     cards_left, {ready, shoe_empty, deal_valid});
        end
        test_mode = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready(200, n);
        checks++;
        if (n != 53) begin
            errors++;
            $display("FAIL mid_restart: %0d cycles required 53", n);
        end
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        checks++;
        if (deal_valid !== 1'b1 || is_ace !== 1'b1) begin
            errors++;
            $display("FAIL mid_deal: dv=%b ace=%b required 1/1", deal_valid, is_ace);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({deal_valid, card_rank, card_value, is_ace} !== 10'd0) begin
            errors++;
            $display("FAIL mid_drop: dv=%b rank=%0d value=%0d ace=%b required all 0",
                     deal_valid, card_rank, card_value, is_ace);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fixed_order();
        test_empty();
        test_shuffled();
        test_busy();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
Upstream card source for the blackjack game FSM. It holds a 52-card deck, shuffles it in place with an LFSR-driven Fisher–Yates pass, then deals one card per request through a request/valid handshake. A deterministic unshuffled mode exists so verification can predict the exact card sequence.

Parameters:
LFSR_SEED, 16'hACE1, non-zero LFSR value loaded on reset.
DECK_SIZE, 52, number of cards; fixed as 4 suits × 13 ranks.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
test_mode  in  1  1 = skip the shuffle and deal in fixed order; sampled on entry to SHUFFLE
shuffle_req  in  1  single-cycle request to rebuild and reshuffle the deck
deal_req  in  1  single-cycle request for one card
ready  out  1  deck is dealable; deal_req is accepted only when ready=1
deal_valid  out  1  one-cycle strobe; card outputs are valid while it is high
card_rank  out  4  1..13 (1=A, 11=J, 12=Q, 13=K)
card_value  out  4  blackjack value: A=1, 2..10=rank, J/Q/K=10
is_ace  out  1  card_rank==1, qualified by deal_valid
cards_left  out  6  undealt cards, 0..52
shoe_empty  out  1  cards_left==0 and state is READY

Behaviour:
- Reset values (asynchronous, active-high reset): state=INIT, idx=0, ptr=0, lfsr=LFSR_SEED. All outputs are 0, including cards_left=0.
- The LFSR is 16-bit Galois with tap mask 16'hB400. It advances every clock in every state, so deal timing adds entropy.
- States: INIT -> SHUFFLE -> READY. The same path is re-entered from READY on shuffle_req.
- INIT:
  - Writes deck[idx] = (idx mod 13)+1 for idx = 0..51, one entry per cycle, 52 cycles total.
  - Then sets i=51, ptr=0, cards_left=52 and moves to SHUFFLE.
- SHUFFLE:
  - If test_mode=1 on entry, go to READY on the next cycle without permuting.
  - Otherwise, each cycle takes cand = lfsr[5:0].
  - If cand ≤ i: swap deck[i] and deck[cand] in that cycle, then i=i-1.
  - If cand > i: reject the candidate, leave i unchanged and retry next cycle.
  - After the swap at i==1, go to READY.
  - Duration is variable; no bound is guaranteed beyond termination.
- READY:
  - ready=1 unless shoe_empty.
  - If deal_req=1 and cards_left>0, the card is deck[ptr]; ptr increments and cards_left decrements.
  - Next cycle: deal_valid=1 with card_rank, card_value and is_ace registered, for exactly 1 cycle. Latency is 1 clock.
  - Back-to-back deal_req on consecutive cycles is legal and gives one card per cycle.
- Boundary cases:
  - deal_req while ready=0 (INIT, SHUFFLE, or empty) is ignored: no queueing, no strobe, no error.
  - shuffle_req while in INIT or SHUFFLE is ignored.
  - shuffle_req and deal_req in the same READY cycle: shuffle wins, no card is dealt, next state is INIT.
  - Empty shoe: shoe_empty=1 and ready=0 until shuffle_req.
  - Reset asserted mid-shuffle or mid-deal: immediate return to INIT; a pending deal_valid is dropped.
- Outputs while deal_valid=0: card_rank, card_value and is_ace hold 0.
- Arithmetic:
  - cand is compared unsigned, 6-bit vs 6-bit i.
  - card_value is derived combinationally from rank before the output register.

Decomposition:
- Package bj_pkg holds:
  - DECK_SIZE=52, RANKS=13, ACE=1, FACE_VALUE=10.
  - The state encoding constants INIT/SHUFFLE/READY.
  - The function rank_to_value(rank).
- One sub-module: bj_lfsr16. It is a free-running Galois LFSR with a seed parameter, asynchronous reset, and a 16-bit state output.
- The deck array, FSM and deal path live in card_shoe.

Test Plan:
1. Fixed-order sequence: reset, test_mode=1, wait for ready (≥53 cycles), then issue 14 consecutive deal_req pulses.
   -> Ranks 1..13 then 1; values 1,2..10,10,10,10,1; is_ace high on the 1st and 14th cards; deal_valid exactly 1 cycle after each request.
2. Empty shoe: in test_mode, deal 52 cards.
   -> cards_left counts 52→0; shoe_empty=1 and ready=0; a 53rd deal_req gives no deal_valid.
   -> shuffle_req then gives cards_left=52 and ready=1 again.
3. Shuffled deck: test_mode=0, LFSR_SEED=16'hACE1, deal all 52 cards.
   -> Every rank appears exactly 4 times; order differs from scenario 1.
   -> Sequence repeats bit-exactly on a second run from reset with identical request timing.
4. Requests while busy: deal_req pulsed during INIT and during SHUFFLE.
   -> No deal_valid, ptr unchanged; first dealt card after ready equals deck[0].
5. Collision: in READY with 10 cards left, assert shuffle_req and deal_req in the same cycle.
   -> No deal_valid; ready drops next cycle; cards_left returns to 52 after INIT.
6. Reset mid-shuffle: assert reset asynchronously mid-SHUFFLE.
   -> All outputs 0 immediately, with no clock edge needed; after release, INIT restarts and ready rises after ≥53 cycles (test_mode=1).
